// File: rtl/dp_arbiter.sv
// Round-robin arbiter that shares one drawing datapath among NUM_REQ draw sequencers,
// mirroring the datapath's start/finished/instruction/result handshake toward each requester.
//
// state | meaning
// IDLE  | no owner; pick the next pending requester round-robin
// ISSUE | second cycle of the two-cycle start pulse
// HOLD  | start dropped; watchdog cleared
// WAIT  | waiting for finished_dp or watchdog expiry
module dp_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int INSTR_W  = 32,
    parameter int RES_W    = 32,
    parameter int WATCHDOG = 1023
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         start_req,
    input  logic [NUM_REQ*INSTR_W-1:0] instr_req,
    output logic [NUM_REQ-1:0]         finished_req,
    output logic [NUM_REQ*RES_W-1:0]   result_req,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       start_dp,
    output logic [INSTR_W-1:0]         instruction_dp,
    input  logic                       finished_dp,
    input  logic [RES_W-1:0]           result_dp,
    output logic                       timeout_err,
    input  logic                       clear_err
);

    localparam int WD_W  = $clog2(WATCHDOG + 1);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD, S_WAIT} state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   pending_q, pending_d;
    logic [NUM_REQ-1:0]   fin_q, fin_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [INSTR_W-1:0]   ireg_q [NUM_REQ];
    logic [INSTR_W-1:0]   ireg_d [NUM_REQ];
    logic [RES_W-1:0]     res_q [NUM_REQ];
    logic [RES_W-1:0]     res_d [NUM_REQ];
    logic [IDX_W-1:0]     rr_q, rr_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic                 start_q, start_d;
    logic                 err_q, err_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;

    logic                 found;
    logic [IDX_W-1:0]     winner;
    logic [IDX_W-1:0]     cand;

    // Search from rr upward with wrap; first pending index wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(rr_q) + k) % NUM_REQ);
            if (!found && pending_q[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        fin_d     = fin_q;
        grant_d   = grant_q;
        ireg_d    = ireg_q;
        res_d     = res_q;
        rr_d      = rr_q;
        owner_d   = owner_q;
        wd_d      = wd_q;
        start_d   = 1'b0;
        err_d     = err_q;
        instr_d   = instr_q;

        if (clear_err) begin
            err_d = 1'b0;
        end

        for (int i = 0; i < NUM_REQ; i++) begin
            if (start_req[i] && fin_q[i]) begin
                pending_d[i] = 1'b1;
                ireg_d[i]    = instr_req[i*INSTR_W +: INSTR_W];
                fin_d[i]     = 1'b0;
            end
        end

        case (state_q)
            S_IDLE: begin
                grant_d = '0;
                if (found) begin
                    grant_d[winner] = 1'b1;
                    owner_d         = winner;
                    instr_d         = ireg_q[winner];
                    start_d         = 1'b1;
                    rr_d            = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                    state_d         = S_ISSUE;
                end
            end
            S_ISSUE: begin
                start_d = 1'b1;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wd_d = wd_q + 1'b1;
                if (finished_dp) begin
                    res_d[owner_q]     = result_dp;
                    fin_d[owner_q]     = 1'b1;
                    pending_d[owner_q] = 1'b0;
                    grant_d            = '0;
                    state_d            = S_IDLE;
                end else if (wd_q == WD_W'(WATCHDOG)) begin
                    // Hung datapath: release the owner with a zero result; set beats clear.
                    res_d[owner_q]     = '0;
                    fin_d[owner_q]     = 1'b1;
                    pending_d[owner_q] = 1'b0;
                    err_d              = 1'b1;
                    grant_d            = '0;
                    state_d            = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            fin_q     <= '1;
            grant_q   <= '0;
            rr_q      <= '0;
            owner_q   <= '0;
            wd_q      <= '0;
            start_q   <= 1'b0;
            err_q     <= 1'b0;
            instr_q   <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                ireg_q[i] <= '0;
                res_q[i]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            fin_q     <= fin_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            owner_q   <= owner_d;
            wd_q      <= wd_d;
            start_q   <= start_d;
            err_q     <= err_d;
            instr_q   <= instr_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                ireg_q[i] <= ireg_d[i];
                res_q[i]  <= res_d[i];
            end
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_res
        assign result_req[i*RES_W +: RES_W] = res_q[i];
    end

    assign finished_req   = fin_q;
    assign grant          = grant_q;
    assign start_dp       = start_q;
    assign instruction_dp = instr_q;
    assign timeout_err    = err_q;

endmodule

// File: tb/tb_dp_arbiter.sv
// Bench for dp_arbiter: directed scenarios plus random traffic, every cycle compared
// against a transaction-age reference model of the arbiter.
module tb_dp_arbiter;

    localparam int N  = 4;
    localparam int IW = 32;
    localparam int RW = 32;
    localparam int WD = 1023;

    logic              clock = 1'b0;
    logic              reset;
    logic [N-1:0]      start_req = '0;
    logic [N*IW-1:0]   instr_req = '0;
    logic [N-1:0]      finished_req;
    logic [N*RW-1:0]   result_req;
    logic [N-1:0]      grant;
    logic              start_dp;
    logic [IW-1:0]     instruction_dp;
    logic              finished_dp = 1'b1;
    logic [RW-1:0]     result_dp = '0;
    logic              timeout_err;
    logic              clear_err = 1'b0;

    dp_arbiter #(.NUM_REQ(N), .INSTR_W(IW), .RES_W(RW), .WATCHDOG(WD)) dut (
        .clock(clock), .reset(reset), .start_req(start_req), .instr_req(instr_req),
        .finished_req(finished_req), .result_req(result_req), .grant(grant),
        .start_dp(start_dp), .instruction_dp(instruction_dp), .finished_dp(finished_dp),
        .result_dp(result_dp), .timeout_err(timeout_err), .clear_err(clear_err)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: per-port busy/pending/latched instruction, owner and its age in cycles.
    bit          m_busy [N];
    bit          m_pend [N];
    logic [IW-1:0] m_instr [N];
    logic [RW-1:0] m_res [N];
    int          m_rr, m_owner, m_age;
    logic [IW-1:0] m_idp;
    bit          m_err;

    int          hold [N];
    bit          dp_hang, dp_late_en, dp_skip, dp_prev, dp_use_fixed;
    int          dp_cnt, dp_dmin, dp_dmax;
    logic [RW-1:0] dp_fixed;
    int          glog [$];
    logic [IW-1:0] ilog [$];
    bit          gl_prev;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [RW-1:0] dp_func(input logic [IW-1:0] x);
        return {x[15:0], x[31:16]} ^ 32'hA5A5_0F0F;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 0; m_pend[i] = 0; m_instr[i] = '0; m_res[i] = '0;
        end
        m_rr = 0; m_owner = -1; m_age = 0; m_idp = '0; m_err = 0;
    endtask

    task automatic model_release(input logic [RW-1:0] val, input bit to);
        m_res[m_owner]  = val;
        m_busy[m_owner] = 0;
        m_pend[m_owner] = 0;
        m_owner = -1;
        if (to) m_err = 1;
    endtask

    task automatic model_step();
        int w;
        int a;
        if (reset) begin
            model_reset();
            return;
        end
        w = -1;
        if (m_owner < 0)
            for (int k = 0; k < N; k++)
                if (w < 0 && m_pend[(m_rr + k) % N]) w = (m_rr + k) % N;
        for (int i = 0; i < N; i++)
            if (start_req[i] && !m_busy[i]) begin
                m_busy[i] = 1; m_pend[i] = 1; m_instr[i] = instr_req[i*IW +: IW];
            end
        if (clear_err) m_err = 0;
        if (w >= 0) begin
            m_owner = w; m_age = 0; m_rr = (w + 1) % N; m_idp = m_instr[w];
        end else if (m_owner >= 0) begin
            a = m_age;
            m_age++;
            if (a >= 2 && finished_dp) model_release(result_dp, 0);
            else if (a >= 2 && (a - 2) == WD) model_release('0, 1);
        end
    endtask

    task automatic compare_all();
        logic [N-1:0] eg;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("finished_req[%0d]", i), 64'(finished_req[i]), 64'(!m_busy[i]));
            chk($sformatf("result_req[%0d]", i), 64'(result_req[i*RW +: RW]), 64'(m_res[i]));
        end
        chk("grant", 64'(grant), 64'(eg));
        chk("start_dp", 64'(start_dp), 64'(m_owner >= 0 && m_age < 2));
        chk("instruction_dp", 64'(instruction_dp), 64'(m_idp));
        chk("timeout_err", 64'(timeout_err), 64'(m_err));
    endtask

    // Datapath stand-in: finished drops on start (sometimes one cycle late), returns after a delay.
    task automatic dp_drive();
        if (reset) begin
            finished_dp = 1; dp_prev = 0; dp_skip = 0;
            return;
        end
        if (start_dp && !dp_prev) begin
            dp_skip = dp_late_en && ($urandom_range(1) == 1);
            if (!dp_skip) begin
                finished_dp = 0; dp_cnt = $urandom_range(dp_dmax, dp_dmin);
            end
        end else if (start_dp && dp_skip) begin
            finished_dp = 0; dp_cnt = $urandom_range(dp_dmax, dp_dmin); dp_skip = 0;
        end else if (!start_dp && !finished_dp && !dp_hang) begin
            dp_cnt--;
            if (dp_cnt <= 0) begin
                finished_dp = 1;
                result_dp = dp_use_fixed ? dp_fixed : dp_func(instruction_dp);
            end
        end
        if (!finished_dp) result_dp = $urandom();
        dp_prev = start_dp;
    endtask

    task automatic tick();
        int g;
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare_all();
        if (start_dp && !gl_prev) begin
            g = -1;
            for (int i = 0; i < N; i++) if (grant[i]) g = i;
            glog.push_back(g);
            ilog.push_back(instruction_dp);
        end
        gl_prev = start_dp;
        dp_drive();
    endtask

    task automatic do_reset();
        start_req = '0; clear_err = 0; reset = 1; dp_hang = 0;
        finished_dp = 1; dp_prev = 0; dp_skip = 0; gl_prev = 0;
        for (int i = 0; i < N; i++) hold[i] = 0;
        model_reset();
        glog.delete(); ilog.delete();
        tick(); tick();
        reset = 0;
    endtask

    task automatic run_until_idle(input string tag, input int max);
        bit done;
        done = 0;
        for (int n = 0; n < max && !done; n++) begin
            tick();
            done = (m_owner < 0);
            for (int i = 0; i < N; i++) if (m_busy[i]) done = 0;
        end
        chk(tag, 64'(done), 64'(1));
    endtask

    task automatic rand_req(input int pct);
        for (int i = 0; i < N; i++) begin
            instr_req[i*IW +: IW] = $urandom();
            if (hold[i] > 0) begin
                start_req[i] = 1; hold[i]--;
            end else if ($urandom_range(99) < pct) begin
                start_req[i] = 1; hold[i] = $urandom_range(3, 1);
            end else begin
                start_req[i] = 0;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit reached;
        logic [IW-1:0] ia;
        dp_late_en = 0; dp_use_fixed = 0; dp_fixed = '0; dp_dmin = 1; dp_dmax = 1; dp_cnt = 0;
        reset = 1;
        do_reset();

        // Single request on port 1, fixed result 0xABCD after 5 cycles.
        dp_use_fixed = 1; dp_fixed = 32'hABCD; dp_dmin = 5; dp_dmax = 5;
        start_req = 4'b0010; instr_req[IW +: IW] = 32'h1005_0A14;
        tick(); tick();
        start_req = '0;
        run_until_idle("t1_idle", 50);
        chk("t1_res", 64'(result_req[IW +: RW]), 64'(32'hABCD));
        chk("t1_grants", 64'(glog.size()), 64'(1));
        chk("t1_owner", 64'(glog[0]), 64'(1));
        dp_use_fixed = 0;

        // Simultaneous ports 0 and 2.
        do_reset();
        dp_dmin = 3; dp_dmax = 3;
        instr_req = {32'h2222_0002, 32'h0, 32'h0000_0000, 32'h1111_0001};
        start_req = 4'b0101;
        tick(); tick();
        start_req = '0;
        run_until_idle("t2_idle", 60);
        chk("t2_first", 64'(glog[0]), 64'(0));
        chk("t2_second", 64'(glog[1]), 64'(2));

        // All ports requesting continuously.
        do_reset();
        dp_dmin = 1; dp_dmax = 6; dp_late_en = 1;
        start_req = 4'hF;
        for (int n = 0; n < 400 && glog.size() < 12; n++) begin
            for (int i = 0; i < N; i++) instr_req[i*IW +: IW] = $urandom();
            tick();
        end
        start_req = '0;
        chk("t3_count", 64'(glog.size() >= 12), 64'(1));
        run_until_idle("t3_idle", 200);
        for (int k = 0; k < 12 && k < glog.size(); k++)
            chk($sformatf("t3_order[%0d]", k), 64'(glog[k]), 64'(k % 4));

        // Watchdog abort, clear, and set-beats-clear.
        do_reset();
        dp_dmin = 2; dp_dmax = 4; dp_late_en = 0;
        instr_req[0 +: IW] = 32'h3456_789A;
        start_req = 4'b0001; tick(); tick(); start_req = '0;
        run_until_idle("t4_pre", 50);
        dp_hang = 1;
        start_req = 4'b0001; tick(); tick(); start_req = '0;
        run_until_idle("t4_hang", WD + 20);
        chk("t4_err", 64'(timeout_err), 64'(1));
        chk("t4_res0", 64'(result_req[0 +: RW]), 64'(0));
        chk("t4_fin0", 64'(finished_req[0]), 64'(1));
        dp_hang = 0; finished_dp = 1;
        clear_err = 1; tick(); clear_err = 0;
        chk("t4_clear", 64'(timeout_err), 64'(0));
        dp_hang = 1; clear_err = 1;
        start_req = 4'b0010; tick(); tick(); start_req = '0;
        run_until_idle("t4_hang2", WD + 20);
        chk("t4_set_wins", 64'(timeout_err), 64'(1));
        tick();
        chk("t4_clear2", 64'(timeout_err), 64'(0));
        clear_err = 0; dp_hang = 0; finished_dp = 1;
        instr_req[2*IW +: IW] = 32'h0BAD_F00D;
        start_req = 4'b0100; tick(); tick(); start_req = '0;
        run_until_idle("t4_after", 50);
        chk("t4_after_res", 64'(result_req[2*RW +: RW]), 64'(dp_func(32'h0BAD_F00D)));

        // Port 3 holds start for 10 cycles, instruction changes mid-way.
        do_reset();
        dp_dmin = 12; dp_dmax = 12;
        ia = 32'hC0DE_0003;
        start_req = 4'b1000;
        for (int n = 0; n < 10; n++) begin
            instr_req[3*IW +: IW] = (n < 4) ? ia : 32'h7777_7777;
            tick();
        end
        start_req = '0;
        run_until_idle("t5_idle", 80);
        chk("t5_count", 64'(glog.size()), 64'(1));
        chk("t5_owner", 64'(glog[0]), 64'(3));
        chk("t5_instr", 64'(ilog[0]), 64'(ia));

        // Asynchronous reset during WAIT.
        do_reset();
        dp_dmin = 20; dp_dmax = 20;
        start_req = 4'b0011; tick(); tick(); start_req = '0;
        reached = 0;
        for (int n = 0; n < 30 && !reached; n++) begin
            tick();
            reached = (m_owner >= 0 && m_age >= 3);
        end
        chk("t6_reach_wait", 64'(reached), 64'(1));
        #2 reset = 1;
        #1;
        chk("t6_start_dp", 64'(start_dp), 64'(0));
        chk("t6_grant", 64'(grant), 64'(0));
        chk("t6_finished", 64'(finished_req), 64'(4'hF));
        model_reset();
        finished_dp = 1; dp_prev = 0; dp_skip = 0;
        @(negedge clock);
        tick();
        reset = 0;
        glog.delete();
        for (int n = 0; n < 10; n++) tick();
        chk("t6_no_grants", 64'(glog.size()), 64'(0));

        // Random traffic at two loads.
        do_reset();
        dp_dmin = 1; dp_dmax = 8; dp_late_en = 1;
        for (int n = 0; n < 3000; n++) begin
            rand_req(20);
            clear_err = ($urandom_range(99) < 2);
            tick();
        end
        for (int n = 0; n < 1500; n++) begin
            rand_req(70);
            clear_err = 0;
            tick();
        end
        start_req = '0;
        for (int i = 0; i < N; i++) hold[i] = 0;
        run_until_idle("rand_idle", 300);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dp_arbiter.md
Name: dp_arbiter

Overview:
- Shares the single drawing datapath between up to NUM_REQ draw-sequencer FSMs, such as the background fill and sprite and score drawers.
- Toward each requester it presents the same start/finished/instruction/result handshake the datapath itself presents, so requesters need no changes.
- Captures each request's instruction and arbitrates round-robin.
- Drives the datapath with a two-cycle start pulse, then routes the result back to the owning requester.
- A watchdog aborts a transaction if the datapath hangs.

Parameters:
- NUM_REQ, 4, number of requester ports (2..8).
- INSTR_W, 32, instruction width; equals the codebase instruction width (opcode[31:28], pad, plot, colour, y, x).
- RES_W, 32, result width; equals the codebase result width.
- WATCHDOG, 1023, maximum cycles in WAIT before abort; counter width is clog2(WATCHDOG+1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start_req  in  NUM_REQ  per-requester start; held high for at least 2 cycles per request.
- instr_req  in  NUM_REQ*INSTR_W  packed instructions; requester i uses slice [i*INSTR_W +: INSTR_W].
- finished_req  out  NUM_REQ  per-requester finished (level): 1 = idle/result valid.
- result_req  out  NUM_REQ*RES_W  packed per-requester result registers.
- grant  out  NUM_REQ  one-hot current datapath owner; 0 when idle.
- start_dp  out  1  datapath start.
- instruction_dp  out  INSTR_W  datapath instruction.
- finished_dp  in  1  datapath finished (level).
- result_dp  in  RES_W  datapath result.
- timeout_err  out  1  sticky watchdog flag.
- clear_err  in  1  synchronous clear of timeout_err.

Behaviour:
- Reset values (async, active-high): finished_req all 1, result_req 0, grant 0, start_dp 0, instruction_dp 0, timeout_err 0, pending 0, rr pointer 0, state IDLE, watchdog 0.
- Request capture, per port i, every cycle:
  - If start_req[i]=1 and finished_req[i]=1: set pending[i]=1, latch instr_req slice into ireg[i], and clear finished_req[i].
  - All three updates are registered, so finished_req[i] reads 0 from the cycle after start is first sampled.
  - start_req[i] while finished_req[i]=0 is ignored; this covers the 2nd held cycle and re-requests.
- Arbitration: round-robin. Search starts at index rr and wraps modulo NUM_REQ. The first pending index wins. After a grant, rr = winner+1 (wraps).
- FSM:
  - IDLE: grant=0, start_dp=0. If any pending bit (registered value) is set, select winner g, set grant=onehot(g), load instruction_dp=ireg[g], set start_dp=1, go to ISSUE.
  - ISSUE: start_dp=1, go to HOLD.
  - HOLD: start_dp=0, watchdog=0, go to WAIT.
  - WAIT: start_dp=0, watchdog increments.
    - If finished_dp=1: result_req[g]=result_dp, finished_req[g]=1, pending[g]=0, grant=0, go to IDLE.
    - Else if watchdog==WATCHDOG: result_req[g]=0, finished_req[g]=1, pending[g]=0, timeout_err=1, grant=0, go to IDLE.
- start_dp is high for exactly 2 consecutive cycles per transaction. instruction_dp is held stable from IDLE exit until WAIT exit.
- Latency, idle arbiter: start sampled at edge k; pending visible after k; start_dp high after edge k+1. finished_req[g] rises the cycle after finished_dp is sampled high in WAIT.
- A request captured in the same cycle as a completion is eligible in the following IDLE cycle. The IDLE cycle between transactions is mandatory (1-cycle gap minimum).
- finished_dp is ignored outside WAIT.
- clear_err clears timeout_err. If clear_err and a timeout happen in the same cycle, the set wins.
- Reset mid-transaction: immediate return to reset values. The datapath shares reset; captured instructions are discarded.

Test Plan:
1. Single request: reset, port 1 start high 2 cycles, instr 0x1_00_5_0A_14. -> start_dp high 2 cycles with that instruction, grant=0010. Datapath returns finished_dp after 5 cycles with result 0xABCD -> result_req[1]=0xABCD, finished_req[1]=1, grant=0.
2. Simultaneous ports 0 and 2 at the same edge, rr=0 -> port 0 served first, then port 2. One IDLE cycle separates the two start_dp pulses; finished_req[2] stays 0 throughout.
3. All four ports re-request immediately on every finish for 12 transactions -> grant order 0,1,2,3 repeating, no port served twice before the others.
4. Datapath never raises finished_dp, WATCHDOG=1023 -> after 1023 WAIT cycles: finished_req[g]=1, result 0, timeout_err=1. A later clear_err pulse clears timeout_err; the next request proceeds normally.
5. Port 3 holds start_req high 10 cycles while granted, instruction changed mid-way -> a single transaction occurs, using the instruction latched at first sample.
6. reset asserted during WAIT -> asynchronously: start_dp=0, grant=0, finished_req=1111, and all pending requests are lost.
